wb_burst_master: RTL and testbench
==================================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, data width; legal values are 8, 16, 32, 64.
REQ-003 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per command; power of 2, at least 2.
REQ-004 SHALL have parameter MAX_IDLE, default 8, maximum idle cycles inserted after a cycle.
REQ-005 SHALL have port wb_clk_i, in, 1, the single clock.
REQ-006 SHALL have port wb_rst_ni, in, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cmd_valid_i (in, 1) and cmd_ready_o (out, 1), the command handshake.
REQ-008 SHALL have command fields, all in:
- cmd_we_i, 1
- cmd_adr_i, AW
- cmd_sel_i, DW/8
- cmd_cti_i, 3: 000 classic, 001 constant, 010 incrementing
- cmd_bte_i, 2
- cmd_len_i, $clog2(MAX_BURST_LEN)+1, beats
- cmd_idle_i, $clog2(MAX_IDLE)+1
REQ-009 SHALL have write-data stream ports wdat_valid_i (in, 1), wdat_i (in, DW) and wdat_ready_o (out, 1).
REQ-010 SHALL have read-data ports rdat_valid_o (out, 1) and rdat_o (out, DW).
REQ-011 SHALL have status ports done_o (out, 1), err_o (out, 1), rty_o (out, 1) and beats_o (out, $clog2(MAX_BURST_LEN)+1).
REQ-012 SHALL have Wishbone B3 master ports: wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0] (out); wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i (in).

Function
REQ-013 SHALL implement FSM states IDLE, BUS and GAP.
REQ-014 SHALL assert cmd_ready_o only in IDLE; cmd_valid_i & cmd_ready_o SHALL latch every cmd field and enter BUS on the next edge.
REQ-015 SHALL treat cmd_len_i==0 as 1 and cmd_len_i>MAX_BURST_LEN as MAX_BURST_LEN; cmd_cti_i values 011-111 SHALL be treated as 010.
REQ-016 SHALL, in BUS, hold wb_cyc_o=1 and wb_we_o/wb_sel_o at the latched values.
REQ-017 SHALL drive wb_stb_o = BUS & (!we | wdat_valid_i); during writes wb_dat_o = wdat_i, and during reads wb_dat_o = 0.
REQ-018 A beat SHALL complete on wb_stb_o & wb_ack_i:
- wdat_ready_o = beat & we (combinational).
- On a read beat, rdat_valid_o pulses 1 cycle on the next edge with rdat_o = captured wb_dat_i.
REQ-019 SHALL generate wb_cti_o as follows:
- classic command: 000 on every beat;
- effective length 1: 111;
- otherwise: latched cti (001/010) on non-final beats and 111 on the final beat.
REQ-020 SHALL drive wb_bte_o = latched bte for incrementing bursts and 00 otherwise.
REQ-021 SHALL advance wb_adr_o after each beat, with B = DW/8:
- constant or classic: unchanged;
- bte 00: +B;
- bte 01/10/11: +B, wrapping within an aligned block of 4/8/16 beats (low address bits only; upper bits unchanged).
REQ-022 SHALL hold wb_adr_o unchanged while wb_stb_o=0 (write stall).
REQ-023 SHALL end BUS on the final acked beat, or on wb_err_i or wb_rty_i sampled with wb_stb_o=1, whichever comes first.
REQ-024 SHALL, on BUS exit, on the same edge:
- drop wb_cyc_o and wb_stb_o;
- force wb_cti_o, wb_bte_o, wb_adr_o, wb_sel_o, wb_dat_o and wb_we_o to 0;
- pulse done_o for 1 cycle, with err_o and rty_o reflecting the terminating condition;
- set beats_o to the count of acked beats.
REQ-025 err_o, rty_o and beats_o SHALL hold until the next done_o.
REQ-026 SHALL give priority ack > err > rty if several are asserted together; the beat counts only on ack.
REQ-027 SHALL, in GAP, wait for the latched idle count (0 means return to IDLE on the next edge; values are clamped to MAX_IDLE) before returning to IDLE.
REQ-028 SHALL have zero-wait-state throughput of one beat per clock.
REQ-029 SHALL have a command-to-first-stb latency of 1 cycle.

Reset
REQ-030 SHALL, while wb_rst_ni=0 (asynchronously, including mid-burst):
- enter IDLE;
- drive all Wishbone outputs, rdat_valid_o, rdat_o, done_o, err_o, rty_o and beats_o to 0;
- drive cmd_ready_o 0;
- drive wdat_ready_o 0.
REQ-031 SHALL assert cmd_ready_o in the first cycle after wb_rst_ni rises.

Verification
REQ-032 Incrementing write, len 4, adr 0x100, bte 00, slave acks every cycle -> adr 0x100/104/108/10C, cti 010,010,010,111, done_o 1 cycle after 4th ack, beats_o=4, err_o=0.
REQ-033 Wrap-4 read, adr 0x0C, DW=32 -> adr 0x0C,0x00,0x04,0x08; 4 rdat_valid_o pulses carrying slave data in order.
REQ-034 Write, len 3, with wdat_valid_i low for 2 cycles before beat 2 -> wb_stb_o low and adr held for those cycles; no beat lost; beats_o=3.
REQ-035 wb_err_i on beat 2 of a len-8 burst -> cyc/stb drop on the same edge, done_o with err_o=1, beats_o=1.
REQ-036 Classic read, idle=3, followed by a pending second command -> cti 000, then 3 GAP cycles, then cmd_ready_o=1.
REQ-037 wb_rst_ni pulled low mid-burst for 1 cycle -> wb_cyc_o=0 immediately; no done_o; cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and a slave.
// Latency: none, plain wires.
// Backpressure: the slave throttles the master through wb_ack_i; err/rty end the cycle.
interface wb_burst_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one accepted command becomes one bus cycle of up to MAX_BURST_LEN beats.
// Latency: first strobe 1 cycle after command accept, one beat per clock with zero wait states.
// Backpressure: write beats stall (stb low, address held) while wdat_valid_i is low; slave stalls with ack.
module wb_burst_master #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int MAX_IDLE      = 8,
  localparam int LW = $clog2(MAX_BURST_LEN) + 1,
  localparam int IW = $clog2(MAX_IDLE) + 1,
  localparam int SW = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [SW-1:0] cmd_sel_i,
  input  logic [2:0]    cmd_cti_i,
  input  logic [1:0]    cmd_bte_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [IW-1:0] cmd_idle_i,
  input  logic          wdat_valid_i,
  input  logic [DW-1:0] wdat_i,
  output logic          wdat_ready_o,
  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,
  output logic          done_o,
  output logic          err_o,
  output logic          rty_o,
  output logic [LW-1:0] beats_o,
  wb_burst_master_if.master wb
);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP} state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [SW-1:0] sel_q;
  logic [2:0]    cti_q;
  logic [1:0]    bte_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [IW-1:0] gap_q;

  logic          in_bus, cmd_fire, beat, fail_err, fail_rty, last_beat, bus_end;
  logic [LW-1:0] len_eff;
  logic [2:0]    cti_eff;
  logic [IW-1:0] idle_eff;
  logic [AW-1:0] wrap_mask, adr_inc, adr_nxt;
  logic [2:0]    cti_out;

  // Ready is also gated by reset so the handshake stays closed while reset is held.
  assign cmd_ready_o = (state_q == S_IDLE) & wb_rst_ni;
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign in_bus      = (state_q == S_BUS);

  // ack wins over err, err wins over rty; only ack counts a beat.
  assign beat      = wb.wb_stb_o & wb.wb_ack_i;
  assign fail_err  = wb.wb_stb_o & ~wb.wb_ack_i & wb.wb_err_i;
  assign fail_rty  = wb.wb_stb_o & ~wb.wb_ack_i & ~wb.wb_err_i & wb.wb_rty_i;
  assign last_beat = (cnt_q == len_q - LW'(1));
  assign bus_end   = in_bus & ((beat & last_beat) | fail_err | fail_rty);

  // Command fields normalised once at accept time.
  assign len_eff  = (cmd_len_i == '0) ? LW'(1) :
                    (cmd_len_i > LW'(MAX_BURST_LEN)) ? LW'(MAX_BURST_LEN) : cmd_len_i;
  assign cti_eff  = (cmd_cti_i > CTI_INCR) ? CTI_INCR : cmd_cti_i;
  assign idle_eff = (cmd_idle_i > IW'(MAX_IDLE)) ? IW'(MAX_IDLE) : cmd_idle_i;

  // Wrap mask covers the byte offset inside the aligned 4/8/16-beat block; all ones means linear.
  always_comb begin
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = AW'(4 * SW - 1);
      2'b10:   wrap_mask = AW'(8 * SW - 1);
      2'b11:   wrap_mask = AW'(16 * SW - 1);
      default: wrap_mask = '1;
    endcase
  end

  assign adr_inc = adr_q + AW'(SW);
  assign adr_nxt = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);

  // Bus outputs are all forced to zero outside BUS, so exit and reset need no extra clearing.
  assign wb.wb_cyc_o  = in_bus;
  assign wb.wb_stb_o  = in_bus & (~we_q | wdat_valid_i);
  assign wb.wb_we_o   = in_bus & we_q;
  assign wb.wb_sel_o  = in_bus ? sel_q : '0;
  assign wb.wb_adr_o  = in_bus ? adr_q : '0;
  assign wb.wb_dat_o  = (in_bus & we_q) ? wdat_i : '0;
  assign wb.wb_bte_o  = (in_bus && cti_q == CTI_INCR) ? bte_q : 2'b00;
  assign wb.wb_cti_o  = cti_out;
  assign wdat_ready_o = beat & we_q;

  // Cycle type: classic stays 000, bursts flag the final beat with end-of-burst.
  always_comb begin
    cti_out = CTI_CLASSIC;
    if (in_bus && cti_q != CTI_CLASSIC) begin
      cti_out = last_beat ? CTI_EOB : cti_q;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state: IDLE -> BUS on accept, BUS -> GAP on termination, GAP -> IDLE after the idle count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_BUS;
      S_BUS:   if (bus_end) state_d = S_GAP;
      S_GAP:   if (gap_q <= IW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched command, beat counter, running address and gap countdown.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      cti_q <= CTI_CLASSIC;
      bte_q <= 2'b00;
      len_q <= LW'(1);
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      if (cmd_fire) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i;
        sel_q <= cmd_sel_i;
        cti_q <= cti_eff;
        bte_q <= cmd_bte_i;
        len_q <= len_eff;
        cnt_q <= '0;
        gap_q <= idle_eff;
      end else if (beat) begin
        cnt_q <= cnt_q + LW'(1);
        if (cti_q == CTI_INCR) adr_q <= adr_nxt;
      end
      if (state_q == S_GAP && gap_q > IW'(1)) gap_q <= gap_q - IW'(1);
    end
  end

  // Read capture and completion status; status holds until the next completion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rty_o        <= 1'b0;
      beats_o      <= '0;
    end else begin
      rdat_valid_o <= beat & ~we_q;
      if (beat & ~we_q) rdat_o <= wb.wb_dat_i;
      done_o <= bus_end;
      if (bus_end) begin
        err_o   <= fail_err;
        rty_o   <= fail_rty;
        beats_o <= beat ? cnt_q + LW'(1) : cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Testbench for wb_burst_master: directed vector table, reset sequences and randomized commands.
// Latency: checks first strobe one cycle after accept and completion one cycle after the last beat.
// Backpressure: exercises write-data stalls, slave wait states and err/rty terminations.
`timescale 1ns/1ps
module tb_wb_burst_master;
  localparam int AW = 32, DW = 32, MBL = 16, MI = 8, LW = 5, IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [3:0]    cmd_sel_i = '0;
  logic [2:0]    cmd_cti_i = '0;
  logic [1:0]    cmd_bte_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [IW-1:0] cmd_idle_i = '0;
  logic          wdat_valid_i = 1'b0, wdat_ready_o, rdat_valid_o, done_o, err_o, rty_o;
  logic [DW-1:0] wdat_i = '0, rdat_o;
  logic [LW-1:0] beats_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_burst_master_if #(.AW(AW), .DW(DW)) wb ();

  wb_burst_master #(.AW(AW), .DW(DW), .MAX_BURST_LEN(MBL), .MAX_IDLE(MI)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_cti_i(cmd_cti_i), .cmd_bte_i(cmd_bte_i),
    .cmd_len_i(cmd_len_i), .cmd_idle_i(cmd_idle_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i), .wdat_ready_o(wdat_ready_o),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o),
    .done_o(done_o), .err_o(err_o), .rty_o(rty_o), .beats_o(beats_o),
    .wb(wb)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [4:0]  len;
    logic [3:0]  idle;
  } cmd_t;

  // term_kind: 0 none, 1 err, 2 rty, 3 ack+err together (ack wins), 4 err+rty together (err wins)
  typedef struct {
    cmd_t        c;
    int          term_beat;
    int          term_kind;
    int          stall_beat;
    int          stall_cyc;
    int          exp_beats;
    bit          exp_err;
    bit          exp_rty;
    logic [31:0] exp_last_adr;
    int          exp_gap;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_len(cmd_t c);
    if (c.len == 0) return 1;
    if (int'(c.len) > MBL) return MBL;
    return int'(c.len);
  endfunction

  function automatic bit is_incr(cmd_t c);
    return c.cti >= 3'd2;
  endfunction

  function automatic logic [31:0] m_adr(cmd_t c, int k);
    logic [31:0] blk, base;
    if (!is_incr(c)) return c.adr;
    if (c.bte == 2'd0) return c.adr + 32'(k * 4);
    blk  = 32'((2 << c.bte) * 4);
    base = c.adr - (c.adr % blk);
    return base + (((c.adr % blk) + 32'(k * 4)) % blk);
  endfunction

  function automatic logic [2:0] m_cti(cmd_t c, int k);
    if (c.cti == 3'd0) return 3'd0;
    if (k == eff_len(c) - 1) return 3'd7;
    return (c.cti == 3'd1) ? 3'd1 : 3'd2;
  endfunction

  function automatic int m_gap(cmd_t c);
    int i;
    i = (int'(c.idle) > MI) ? MI : int'(c.idle);
    return (i == 0) ? 1 : i;
  endfunction

  function automatic bit m_term(cmd_t c, int tbt, int tk);
    return (tk == 1 || tk == 2 || tk == 4) && tbt >= 0 && tbt < eff_len(c);
  endfunction

  function automatic int m_beats(cmd_t c, int tbt, int tk);
    return m_term(c, tbt, tk) ? tbt : eff_len(c);
  endfunction

  function automatic vec_t mk(bit we, logic [31:0] adr, logic [2:0] cti, logic [1:0] bte,
                              logic [4:0] len, logic [3:0] idle, int tbt, int tk, int sb, int sc,
                              int eb, bit ee, bit er, logic [31:0] ela, int eg);
    vec_t v;
    v.c.we = we; v.c.adr = adr; v.c.sel = 4'hF; v.c.cti = cti; v.c.bte = bte;
    v.c.len = len; v.c.idle = idle;
    v.term_beat = tbt; v.term_kind = tk; v.stall_beat = sb; v.stall_cyc = sc;
    v.exp_beats = eb; v.exp_err = ee; v.exp_rty = er; v.exp_last_adr = ela; v.exp_gap = eg;
    return v;
  endfunction

  // ---------------- one command, bus slave included ----------------
  task automatic run_cmd(input cmd_t c, input int tbt, input int tk, input int sb, input int sc,
                         input bit rnd, output int o_beats, output bit o_err, output bit o_rty,
                         output logic [31:0] o_last_adr, output int o_gap);
    logic [31:0] sent[$];
    logic [31:0] got[$];
    logic [31:0] d;
    int n, beat, k, stall_left, exp_b;
    bit fin, ack, exp_e, exp_r;
    n = eff_len(c); beat = 0; fin = 0; stall_left = sc; d = '0;
    exp_b = m_beats(c, tbt, tk);
    exp_e = m_term(c, tbt, tk) && tk != 2;
    exp_r = m_term(c, tbt, tk) && tk == 2;
    o_last_adr = '0; o_gap = 0;

    @(negedge clk);
    cmd_we_i = c.we; cmd_adr_i = c.adr; cmd_sel_i = c.sel; cmd_cti_i = c.cti;
    cmd_bte_i = c.bte; cmd_len_i = c.len; cmd_idle_i = c.idle; cmd_valid_i = 1'b1;
    #1 chk("cmd_ready_idle", cmd_ready_o, 1);

    k = 0;
    while (!fin && k < 300) begin
      @(negedge clk);
      cmd_valid_i = 1'b0;
      wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0; ack = 0;
      wdat_i = $urandom;
      if (!c.we) wdat_valid_i = 1'($urandom_range(1));
      else if (rnd) wdat_valid_i = ($urandom_range(3) != 0);
      else if (beat == sb && stall_left > 0) begin wdat_valid_i = 1'b0; stall_left--; end
      else wdat_valid_i = 1'b1;
      #1;
      chk("cyc_in_bus", wb.wb_cyc_o, 1);
      chk("cmd_ready_in_bus", cmd_ready_o, 0);
      chk("done_in_bus", done_o, 0);
      chk("stb", wb.wb_stb_o, !c.we || wdat_valid_i);
      chk("adr", wb.wb_adr_o, m_adr(c, beat));
      if (wb.wb_stb_o) begin
        chk("cti", wb.wb_cti_o, m_cti(c, beat));
        chk("bte", wb.wb_bte_o, is_incr(c) ? c.bte : 2'd0);
        chk("we", wb.wb_we_o, c.we);
        chk("sel", wb.wb_sel_o, c.sel);
        chk("dat_o", wb.wb_dat_o, c.we ? wdat_i : 32'd0);
        o_last_adr = wb.wb_adr_o;
        if (!(rnd && $urandom_range(3) == 0)) begin
          if (beat == tbt && tk == 1) wb.wb_err_i = 1;
          else if (beat == tbt && tk == 2) wb.wb_rty_i = 1;
          else if (beat == tbt && tk == 4) begin wb.wb_err_i = 1; wb.wb_rty_i = 1; end
          else begin
            ack = 1; wb.wb_ack_i = 1; d = $urandom; wb.wb_dat_i = d;
            if (beat == tbt && tk == 3) wb.wb_err_i = 1;
          end
        end
      end
      #1 chk("wdat_ready", wdat_ready_o, ack && c.we);
      if (rdat_valid_o) got.push_back(rdat_o);
      if (ack) begin
        if (!c.we) sent.push_back(d);
        beat++;
        if (beat == n) fin = 1;
      end else if (wb.wb_err_i || wb.wb_rty_i) fin = 1;
      k++;
    end
    if (!fin) chk("bus_timeout", 0, 1);

    // First cycle after the bus cycle: outputs quiet, completion pulse, a pending command held off.
    @(negedge clk);
    wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0; wdat_valid_i = 1'b0;
    cmd_adr_i = $urandom; cmd_len_i = 5'd2; cmd_valid_i = 1'b1;
    #1;
    chk("exit_cyc", wb.wb_cyc_o, 0);
    chk("exit_stb", wb.wb_stb_o, 0);
    chk("exit_adr", wb.wb_adr_o, 0);
    chk("exit_cti", wb.wb_cti_o, 0);
    chk("exit_bte", wb.wb_bte_o, 0);
    chk("exit_we", wb.wb_we_o, 0);
    chk("exit_sel", wb.wb_sel_o, 0);
    chk("exit_dat", wb.wb_dat_o, 0);
    chk("done_pulse", done_o, 1);
    o_beats = int'(beats_o); o_err = err_o; o_rty = rty_o;
    if (rdat_valid_o) got.push_back(rdat_o);

    k = 0;
    while (!cmd_ready_o && k < 40) begin
      o_gap++;
      chk("gap_stb", wb.wb_stb_o, 0);
      if (k > 0) begin
        chk("done_single", done_o, 0);
        chk("beats_hold", beats_o, exp_b);
        chk("err_hold", err_o, exp_e);
        chk("rty_hold", rty_o, exp_r);
      end
      @(negedge clk); #1;
      k++;
    end
    if (k >= 40) chk("gap_timeout", 0, 1);
    cmd_valid_i = 1'b0;

    chk("rdat_count", got.size(), sent.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++) chk("rdat_data", got[i], sent[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ob, og;
    bit oe, orr;
    logic [31:0] ol;
    cmd_t c;
    int tbt, tk;

    wb.wb_dat_i = '0; wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0;

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_cyc", wb.wb_cyc_o, 0);
    chk("rst_stb", wb.wb_stb_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_beats", beats_o, 0);
    chk("rst_rdat_valid", rdat_valid_o, 0);
    chk("rst_wdat_ready", wdat_ready_o, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_ready", cmd_ready_o, 1);

    //         we  adr      cti   bte   len    idle  tbt tk sb sc  beats err rty last     gap
    vt.push_back(mk(1, 32'h100, 3'd2, 2'd0, 5'd4,  4'd0, -1, 0, -1, 0, 4,  0, 0, 32'h10C, 1));
    vt.push_back(mk(0, 32'h00C, 3'd2, 2'd1, 5'd4,  4'd2, -1, 0, -1, 0, 4,  0, 0, 32'h008, 2));
    vt.push_back(mk(1, 32'h200, 3'd2, 2'd0, 5'd3,  4'd1, -1, 0,  1, 2, 3,  0, 0, 32'h208, 1));
    vt.push_back(mk(0, 32'h040, 3'd2, 2'd0, 5'd8,  4'd0,  1, 1, -1, 0, 1,  1, 0, 32'h044, 1));
    vt.push_back(mk(0, 32'h300, 3'd0, 2'd0, 5'd1,  4'd3, -1, 0, -1, 0, 1,  0, 0, 32'h300, 3));
    vt.push_back(mk(1, 32'h300, 3'd0, 2'd2, 5'd4,  4'd0, -1, 0, -1, 0, 4,  0, 0, 32'h300, 1));
    vt.push_back(mk(0, 32'h500, 3'd2, 2'd0, 5'd0,  4'd0, -1, 0, -1, 0, 1,  0, 0, 32'h500, 1));
    vt.push_back(mk(0, 32'h1000,3'd2, 2'd0, 5'd20, 4'd0, -1, 0, -1, 0, 16, 0, 0, 32'h103C,1));
    vt.push_back(mk(0, 32'h038, 3'd5, 2'd2, 5'd8,  4'd12,-1, 0, -1, 0, 8,  0, 0, 32'h034, 8));
    vt.push_back(mk(1, 32'h600, 3'd1, 2'd0, 5'd4,  4'd0,  0, 2, -1, 0, 0,  0, 1, 32'h600, 1));
    vt.push_back(mk(0, 32'h700, 3'd1, 2'd3, 5'd3,  4'd0, -1, 0, -1, 0, 3,  0, 0, 32'h700, 1));
    vt.push_back(mk(1, 32'h8F8, 3'd2, 2'd3, 5'd16, 4'd0, -1, 0, -1, 0, 16, 0, 0, 32'h8F4, 1));
    vt.push_back(mk(0, 32'h040, 3'd2, 2'd0, 5'd2,  4'd0,  0, 3, -1, 0, 2,  0, 0, 32'h044, 1));
    vt.push_back(mk(1, 32'hA00, 3'd2, 2'd0, 5'd4,  4'd0,  2, 4, -1, 0, 2,  1, 0, 32'hA08, 1));

    foreach (vt[i]) begin
      run_cmd(vt[i].c, vt[i].term_beat, vt[i].term_kind, vt[i].stall_beat, vt[i].stall_cyc,
              1'b0, ob, oe, orr, ol, og);
      chk($sformatf("vec%0d_beats", i), ob, vt[i].exp_beats);
      chk($sformatf("vec%0d_err", i), oe, vt[i].exp_err);
      chk($sformatf("vec%0d_rty", i), orr, vt[i].exp_rty);
      chk($sformatf("vec%0d_last_adr", i), ol, vt[i].exp_last_adr);
      chk($sformatf("vec%0d_gap", i), og, vt[i].exp_gap);
    end

    // Reset pulled mid-burst: bus drops at once, no completion, ready right after release.
    @(negedge clk);
    cmd_we_i = 1'b0; cmd_adr_i = 32'h900; cmd_sel_i = 4'hF; cmd_cti_i = 3'd2; cmd_bte_i = 2'd0;
    cmd_len_i = 5'd8; cmd_idle_i = 4'd2; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0; wb.wb_ack_i = 1; wb.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    wb.wb_ack_i = 0;
    #1 chk("midburst_cyc_before", wb.wb_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midburst_rst_cyc", wb.wb_cyc_o, 0);
    chk("midburst_rst_stb", wb.wb_stb_o, 0);
    chk("midburst_rst_ready", cmd_ready_o, 0);
    chk("midburst_rst_done", done_o, 0);
    chk("midburst_rst_rdat_valid", rdat_valid_o, 0);
    chk("midburst_rst_beats", beats_o, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midburst_release_ready", cmd_ready_o, 1);
    @(negedge clk); #1;
    chk("midburst_no_done", done_o, 0);
    chk("midburst_idle_cyc", wb.wb_cyc_o, 0);

    // Randomized commands against the model.
    for (int r = 0; r < 40; r++) begin
      c.we = 1'($urandom_range(1)); c.adr = $urandom; c.sel = 4'($urandom);
      c.cti = 3'($urandom_range(7)); c.bte = 2'($urandom_range(3));
      c.len = 5'($urandom_range(20)); c.idle = 4'($urandom_range(11));
      tk  = ($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0;
      tbt = int'($urandom_range(eff_len(c) - 1));
      run_cmd(c, tbt, tk, -1, 0, 1'b1, ob, oe, orr, ol, og);
      chk($sformatf("rnd%0d_beats", r), ob, m_beats(c, tbt, tk));
      chk($sformatf("rnd%0d_err", r), oe, m_term(c, tbt, tk) && tk != 2);
      chk($sformatf("rnd%0d_rty", r), orr, m_term(c, tbt, tk) && tk == 2);
      chk($sformatf("rnd%0d_last_adr", r), ol, m_adr(c, m_term(c, tbt, tk) ? tbt : eff_len(c) - 1));
      chk($sformatf("rnd%0d_gap", r), og, m_gap(c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
